jtframe_romrq_arb: RTL and testbench
====================================

Name: jtframe_romrq_arb

Overview:
- Two-slot ROM request arbiter with a one-word cache per slot.
- Sits directly upstream of the MiST frame top. It converts game-side ROM reads (slot address, chip select) into the frame's sdram_req / sdram_addr / sdram_ack / data_read / data_rdy handshake.
- It returns the selected sub-word to each slot with a valid flag.
- One arbiter per game core; two slots cover a typical CPU ROM plus a graphics ROM.

Parameters:
- SLOT0_AW, 17: slot 0 address width, in SLOT0_DW units.
- SLOT0_DW, 8: slot 0 data width; legal values are 8, 16, 32.
- SLOT0_OFFSET, 22'h00_0000: slot 0 base, in SDRAM 16-bit word units.
- SLOT1_AW, 15: slot 1 address width.
- SLOT1_DW, 16: slot 1 data width; legal values are 8, 16, 32.
- SLOT1_OFFSET, 22'h01_0000: slot 1 base, in SDRAM 16-bit word units.

Ports:
- clk_rom  in  1  ROM/SDRAM clock; the block's only clock.
- rst  in  1  asynchronous, active-high reset.
- downloading  in  1  ROM download in progress.
- loop_rst  in  1  SDRAM controller loop reset; aborts the transfer in flight.
- slot0_cs  in  1  slot 0 read request.
- slot0_addr  in  SLOT0_AW  slot 0 address.
- slot0_dout  out  SLOT0_DW  slot 0 data.
- slot0_ok  out  1  slot 0 data valid for the current address.
- slot1_cs, slot1_addr, slot1_dout, slot1_ok: same as slot 0, using SLOT1_* widths.
- sdram_req  out  1  request to the SDRAM controller.
- sdram_addr  out  22  16-bit-word address; always even.
- sdram_ack  in  1  controller accepted the request.
- data_read  in  32  read data: word at addr in [15:0], addr+1 in [31:16].
- data_rdy  in  1  data_read valid, one-cycle pulse.

Behaviour:
- Reset (async, rst=1):
  - sdram_req=0, sdram_addr=0.
  - State IDLE, both cache valid bits 0, round-robin pointer = slot 0.
  - slotN_ok=0 and slotN_dout=0 (cache data cleared).
- Per-slot cache:
  - Holds a 32-bit data word, a tag and a valid bit.
  - Tag = slot address with the sub-word bits dropped: DW8 drops [1:0], DW16 drops [0], DW32 drops nothing.
  - hitN = valid & (tag == current tag of slotN_addr).
  - slotN_ok = slotN_cs & hitN. This is combinational from the registered cache, so a hit is zero-latency.
- slotN_dout: the sub-word selected by the dropped address bits, little-endian (sub 0 = bits [DW-1:0]). It is valid only when ok=1.
- SDRAM address: OFFSET + (tag << 1).
- FSM:
  - IDLE:
    - Candidates = slots with cs & ~hit.
    - If both are candidates, grant the slot named by the pointer, then toggle the pointer.
    - If one is a candidate, grant it; the pointer is set to the other slot.
    - On grant: latch slot id and tag, drive sdram_addr, set sdram_req=1, go to WAIT_ACK.
    - Issue happens the cycle after the miss is seen; no new grant is made while not in IDLE.
  - WAIT_ACK: hold sdram_req and sdram_addr stable. On sdram_ack, sdram_req goes 0 next cycle and the FSM goes to WAIT_RDY.
  - WAIT_RDY:
    - On data_rdy, write data_read and the latched tag to the granted slot's cache, set valid=1, go to IDLE.
    - ok can rise the cycle after data_rdy.
  - data_rdy without ack in the same cycle: accepted in WAIT_ACK only if ack was already seen. A data_rdy in IDLE or WAIT_ACK is ignored.
- Slot address change mid-flight:
  - The transfer completes and the old tag is stored.
  - ok stays 0 for the new address, which raises a fresh miss in IDLE afterwards.
- cs deasserted mid-flight: the transfer still completes and the cache is filled.
- loop_rst=1:
  - Synchronous abort: the next state is IDLE and sdram_req=0.
  - Caches are kept; the in-flight fill is discarded.
- downloading=1:
  - Both valid bits are cleared every cycle and the FSM is forced to IDLE with sdram_req=0.
  - No grants while it is high; ok=0.
  - The first miss is issued the cycle after downloading falls.
- Simultaneous data_rdy and loop_rst: loop_rst wins; no cache write.
- rst asserted mid-transfer: immediate return to the reset state.

Decomposition:
- Package jtframe_romrq_pkg holds:
  - the state enum (IDLE, WAIT_ACK, WAIT_RDY);
  - localparam function subw(DW), returning the number of dropped address bits (0, 1 or 2);
  - the SDRAM address width constant 22.
- One natural sub-module, jtframe_romrq_cache, instantiated twice. It is parameterised by AW, DW and OFFSET and contains:
  - the tag, data and valid registers;
  - hit detection and sub-word mux;
  - the request-address computation;
  - the fill and clear ports.
- The arbiter FSM and round-robin pointer live in the top.

Test Plan:
1. Reset release; slot0_cs=1, slot0_addr=17'h00005.
   - Required: sdram_req=1 with sdram_addr=22'h000002.
   - Then ack, then data_rdy with data_read=32'hDDCCBBAA.
   - slot0_ok=1 and slot0_dout=8'hBB the next cycle. Changing to addr 17'h00007 gives dout=8'hDD with no new request.
2. Both slots miss in the same cycle, pointer=0.
   - Required: slot 0 is served first.
   - Slot 1 (addr 15'h0003) is issued after slot 0 fills, with sdram_addr=22'h010002.
   - In the next simultaneous miss pair, slot 1 is served first.
3. slot1_addr changes from 15'h0000 to 15'h0010 during WAIT_RDY.
   - Required: the fill is stored with the old tag and slot1_ok stays 0.
   - A new request with sdram_addr=22'h010010 follows.
4. loop_rst pulse in WAIT_RDY, then data_rdy in the same cycle.
   - Required: no cache update, sdram_req=0, FSM in IDLE.
   - The miss is reissued on the next cycle.
5. Valid caches on both slots, then downloading=1 for 10 cycles.
   - Required: ok=0 on both slots, no sdram_req.
   - After downloading falls, both slots re-request.
6. rst asserted while sdram_req=1.
   - Required: sdram_req=0 and ok=0 asynchronously.
   - After release, the first miss issues normally.

Source files
------------

// File: rtl/jtframe_romrq_pkg.sv
// Shared types and helpers for the two-slot ROM request arbiter.
package jtframe_romrq_pkg;

  // SDRAM address width, in 16-bit word units
  localparam int SDRAM_AW = 22;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_ACK = 2'd1,
    ST_WAIT_RDY = 2'd2
  } state_t;

  // Number of slot address bits that select a sub-word inside the 32-bit line
  function automatic int subw(input int dw);
    case (dw)
      8:       return 2;
      16:      return 1;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/jtframe_romrq_cache.sv
// One-line (32-bit) cache for a single ROM slot: tag/data/valid storage,
// hit detection, sub-word selection and SDRAM request address.
module jtframe_romrq_cache
  import jtframe_romrq_pkg::*;
#(
  parameter int                  AW     = 17,
  parameter int                  DW     = 8,
  parameter logic [SDRAM_AW-1:0] OFFSET = 22'h00_0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_cs,
  input  logic [AW-1:0]       i_addr,
  input  logic                i_clr,
  input  logic                i_grant,
  input  logic                i_fill,
  input  logic [31:0]         i_fill_data,
  output logic                o_hit,
  output logic                o_ok,
  output logic [DW-1:0]       o_dout,
  output logic [SDRAM_AW-1:0] o_req_addr
);

  localparam int SW = subw(DW);
  localparam int TW = AW - SW;

  logic          r_valid;
  logic [TW-1:0] r_tag;
  logic [TW-1:0] r_pend_tag;
  logic [31:0]   r_data;
  logic [TW-1:0] w_tag;

  assign w_tag      = i_addr[AW-1:SW];
  assign o_hit      = r_valid & (r_tag == w_tag);
  assign o_ok       = i_cs & o_hit;
  // The line is two 16-bit SDRAM words, so the word address is the tag doubled
  assign o_req_addr = OFFSET + SDRAM_AW'({w_tag, 1'b0});

  generate
    if (SW > 0) begin : g_sub
      logic [SW-1:0] w_sub;
      logic [31:0]   w_shifted;
      assign w_sub     = i_addr[SW-1:0];
      assign w_shifted = r_data >> (32'(w_sub) * 32'(DW));
      assign o_dout    = w_shifted[DW-1:0];
    end else begin : g_full
      assign o_dout = r_data[DW-1:0];
    end
  endgenerate

  // Tag captured at grant time; the fill stores it even if the slot address moved on
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid    <= 1'b0;
      r_tag      <= '0;
      r_pend_tag <= '0;
      r_data     <= 32'h0000_0000;
    end else begin
      if (i_grant) begin
        r_pend_tag <= w_tag;
      end
      if (i_clr) begin
        r_valid <= 1'b0;
      end else if (i_fill) begin
        r_valid <= 1'b1;
        r_tag   <= r_pend_tag;
        r_data  <= i_fill_data;
      end
    end
  end

endmodule

// File: rtl/jtframe_romrq_arb.sv
// Two-slot ROM request arbiter: round-robin between slot misses and drives
// the SDRAM req/ack/rdy handshake, filling each slot's one-line cache.
module jtframe_romrq_arb
  import jtframe_romrq_pkg::*;
#(
  parameter int                  SLOT0_AW     = 17,
  parameter int                  SLOT0_DW     = 8,
  parameter logic [SDRAM_AW-1:0] SLOT0_OFFSET = 22'h00_0000,
  parameter int                  SLOT1_AW     = 15,
  parameter int                  SLOT1_DW     = 16,
  parameter logic [SDRAM_AW-1:0] SLOT1_OFFSET = 22'h01_0000
) (
  input  logic                clk_rom,
  input  logic                rst,
  input  logic                downloading,
  input  logic                loop_rst,
  input  logic                slot0_cs,
  input  logic [SLOT0_AW-1:0] slot0_addr,
  output logic [SLOT0_DW-1:0] slot0_dout,
  output logic                slot0_ok,
  input  logic                slot1_cs,
  input  logic [SLOT1_AW-1:0] slot1_addr,
  output logic [SLOT1_DW-1:0] slot1_dout,
  output logic                slot1_ok,
  output logic                sdram_req,
  output logic [SDRAM_AW-1:0] sdram_addr,
  input  logic                sdram_ack,
  input  logic [31:0]         data_read,
  input  logic                data_rdy
);

  state_t              r_st, w_st_nxt;
  logic                r_ptr, w_ptr_nxt;   // slot favoured when both miss
  logic                r_gnt, w_gnt_nxt;   // slot owning the transfer in flight
  logic                r_req, w_req_nxt;
  logic [SDRAM_AW-1:0] r_addr, w_addr_nxt;
  logic                w_hit0, w_hit1;
  logic                w_cand0, w_cand1;
  logic                w_grant0, w_grant1;
  logic                w_fill0, w_fill1;
  logic [SDRAM_AW-1:0] w_req_addr0, w_req_addr1;

  assign sdram_req  = r_req;
  assign sdram_addr = r_addr;
  assign w_cand0    = slot0_cs & ~w_hit0;
  assign w_cand1    = slot1_cs & ~w_hit1;

  jtframe_romrq_cache #(.AW(SLOT0_AW), .DW(SLOT0_DW), .OFFSET(SLOT0_OFFSET)) u_cache0 (
    .clk(clk_rom), .rst(rst), .i_cs(slot0_cs), .i_addr(slot0_addr),
    .i_clr(downloading), .i_grant(w_grant0), .i_fill(w_fill0), .i_fill_data(data_read),
    .o_hit(w_hit0), .o_ok(slot0_ok), .o_dout(slot0_dout), .o_req_addr(w_req_addr0)
  );

  jtframe_romrq_cache #(.AW(SLOT1_AW), .DW(SLOT1_DW), .OFFSET(SLOT1_OFFSET)) u_cache1 (
    .clk(clk_rom), .rst(rst), .i_cs(slot1_cs), .i_addr(slot1_addr),
    .i_clr(downloading), .i_grant(w_grant1), .i_fill(w_fill1), .i_fill_data(data_read),
    .o_hit(w_hit1), .o_ok(slot1_ok), .o_dout(slot1_dout), .o_req_addr(w_req_addr1)
  );

  // Next-state, grant and fill decode; download and loop reset override everything
  always_comb begin
    w_st_nxt   = r_st;
    w_ptr_nxt  = r_ptr;
    w_gnt_nxt  = r_gnt;
    w_req_nxt  = r_req;
    w_addr_nxt = r_addr;
    w_grant0   = 1'b0;
    w_grant1   = 1'b0;
    w_fill0    = 1'b0;
    w_fill1    = 1'b0;
    if (downloading || loop_rst) begin
      w_st_nxt  = ST_IDLE;
      w_req_nxt = 1'b0;
    end else begin
      case (r_st)
        ST_IDLE: begin
          // After any grant the pointer names the slot that was not served
          if (w_cand0 && (!w_cand1 || !r_ptr)) begin
            w_grant0   = 1'b1;
            w_gnt_nxt  = 1'b0;
            w_ptr_nxt  = 1'b1;
            w_req_nxt  = 1'b1;
            w_addr_nxt = w_req_addr0;
            w_st_nxt   = ST_WAIT_ACK;
          end else if (w_cand1) begin
            w_grant1   = 1'b1;
            w_gnt_nxt  = 1'b1;
            w_ptr_nxt  = 1'b0;
            w_req_nxt  = 1'b1;
            w_addr_nxt = w_req_addr1;
            w_st_nxt   = ST_WAIT_ACK;
          end else begin
            w_st_nxt = ST_IDLE;
          end
        end
        ST_WAIT_ACK: begin
          // data_rdy here cannot belong to this request yet, so it is ignored
          if (sdram_ack) begin
            w_req_nxt = 1'b0;
            w_st_nxt  = ST_WAIT_RDY;
          end else begin
            w_st_nxt = ST_WAIT_ACK;
          end
        end
        ST_WAIT_RDY: begin
          if (data_rdy) begin
            w_fill0  = ~r_gnt;
            w_fill1  = r_gnt;
            w_st_nxt = ST_IDLE;
          end else begin
            w_st_nxt = ST_WAIT_RDY;
          end
        end
        default: begin
          w_st_nxt  = ST_IDLE;
          w_req_nxt = 1'b0;
        end
      endcase
    end
  end

  // Arbiter state, pointer and registered SDRAM request outputs
  always_ff @(posedge clk_rom or posedge rst) begin
    if (rst) begin
      r_st   <= ST_IDLE;
      r_ptr  <= 1'b0;
      r_gnt  <= 1'b0;
      r_req  <= 1'b0;
      r_addr <= '0;
    end else begin
      r_st   <= w_st_nxt;
      r_ptr  <= w_ptr_nxt;
      r_gnt  <= w_gnt_nxt;
      r_req  <= w_req_nxt;
      r_addr <= w_addr_nxt;
    end
  end

endmodule

// File: tb/tb_jtframe_romrq_arb.sv
// Directed self-checking bench for jtframe_romrq_arb (default parameters).
module tb_jtframe_romrq_arb;

  logic        clk_rom = 1'b0;
  logic        rst = 1'b1;
  logic        downloading = 1'b0;
  logic        loop_rst = 1'b0;
  logic        slot0_cs = 1'b0;
  logic [16:0] slot0_addr = 17'h0;
  logic [7:0]  slot0_dout;
  logic        slot0_ok;
  logic        slot1_cs = 1'b0;
  logic [14:0] slot1_addr = 15'h0;
  logic [15:0] slot1_dout;
  logic        slot1_ok;
  logic        sdram_req;
  logic [21:0] sdram_addr;
  logic        sdram_ack = 1'b0;
  logic [31:0] data_read = 32'h0;
  logic        data_rdy = 1'b0;

  int n_total = 0;
  int n_bad = 0;

  jtframe_romrq_arb dut (
    .clk_rom(clk_rom), .rst(rst), .downloading(downloading), .loop_rst(loop_rst),
    .slot0_cs(slot0_cs), .slot0_addr(slot0_addr), .slot0_dout(slot0_dout), .slot0_ok(slot0_ok),
    .slot1_cs(slot1_cs), .slot1_addr(slot1_addr), .slot1_dout(slot1_dout), .slot1_ok(slot1_ok),
    .sdram_req(sdram_req), .sdram_addr(sdram_addr), .sdram_ack(sdram_ack),
    .data_read(data_read), .data_rdy(data_rdy)
  );

  always #5 clk_rom = ~clk_rom;

  task automatic step();
    @(posedge clk_rom);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Bounded wait for a request, then check its address
  task automatic wait_req(input string tag, input logic [21:0] exp_addr);
    int n = 0;
    while (!sdram_req && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_req"}, 32'(sdram_req), 32'd1);
    chk({tag, "_addr"}, 32'(sdram_addr), 32'(exp_addr));
  endtask

  task automatic do_ack(input string tag);
    sdram_ack = 1'b1;
    step();
    sdram_ack = 1'b0;
    chk({tag, "_req_drop"}, 32'(sdram_req), 32'd0);
  endtask

  task automatic do_rdy(input logic [31:0] data);
    step();
    data_read = data;
    data_rdy  = 1'b1;
    step();
    data_rdy  = 1'b0;
  endtask

  task automatic serve(input string tag, input logic [21:0] exp_addr, input logic [31:0] data);
    wait_req(tag, exp_addr);
    do_ack(tag);
    do_rdy(data);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    step();
    step();
    chk("rst_req", 32'(sdram_req), 32'd0);
    chk("rst_addr", 32'(sdram_addr), 32'd0);
    chk("rst_ok0", 32'(slot0_ok), 32'd0);
    chk("rst_ok1", 32'(slot1_ok), 32'd0);
    chk("rst_dout0", 32'(slot0_dout), 32'd0);
    chk("rst_dout1", 32'(slot1_dout), 32'd0);

    // Test 1: single miss, fill, sub-word hit without a new request
    rst = 1'b0;
    slot0_cs = 1'b1;
    slot0_addr = 17'h00005;
    step();
    chk("t1_issue_req", 32'(sdram_req), 32'd1);
    chk("t1_issue_addr", 32'(sdram_addr), 32'h000002);
    do_ack("t1");
    do_rdy(32'hDDCC_BBAA);
    chk("t1_ok", 32'(slot0_ok), 32'd1);
    chk("t1_dout", 32'(slot0_dout), 32'h0000_00BB);
    slot0_addr = 17'h00007;
    #1;
    chk("t1_dout7", 32'(slot0_dout), 32'h0000_00DD);
    chk("t1_ok7", 32'(slot0_ok), 32'd1);
    step();
    chk("t1_no_req", 32'(sdram_req), 32'd0);

    // Test 2: simultaneous misses with pointer at slot 0
    rst = 1'b1;
    step();
    rst = 1'b0;
    slot0_addr = 17'h00020;
    slot1_cs = 1'b1;
    slot1_addr = 15'h0003;
    serve("t2_s0", 22'h000010, 32'h4433_2211);
    serve("t2_s1", 22'h010002, 32'h1234_5678);
    chk("t2_ok0", 32'(slot0_ok), 32'd1);
    chk("t2_dout0", 32'(slot0_dout), 32'h0000_0011);
    chk("t2_ok1", 32'(slot1_ok), 32'd1);
    chk("t2_dout1", 32'(slot1_dout), 32'h0000_1234);
    // A lone slot 0 miss leaves the pointer at slot 1 for the next pair
    slot1_cs = 1'b0;
    slot0_addr = 17'h00040;
    serve("t2_lone", 22'h000020, 32'h0000_0000);
    slot0_addr = 17'h00080;
    slot1_cs = 1'b1;
    slot1_addr = 15'h0021;
    serve("t2_pair_s1", 22'h010020, 32'hBEEF_0000);
    serve("t2_pair_s0", 22'h000040, 32'h0000_0077);
    chk("t2_pair_dout1", 32'(slot1_dout), 32'h0000_BEEF);
    chk("t2_pair_dout0", 32'(slot0_dout), 32'h0000_0077);

    // Test 3: slot 1 address moves while the fill is pending
    slot0_cs = 1'b0;
    slot1_addr = 15'h0000;
    wait_req("t3_old", 22'h010000);
    do_ack("t3_old");
    slot1_addr = 15'h0010;
    do_rdy(32'hCAFE_BEEF);
    chk("t3_ok_new", 32'(slot1_ok), 32'd0);
    slot1_addr = 15'h0000;
    #1;
    chk("t3_ok_oldtag", 32'(slot1_ok), 32'd1);
    chk("t3_dout_oldtag", 32'(slot1_dout), 32'h0000_BEEF);
    slot1_addr = 15'h0010;
    #1;
    serve("t3_new", 22'h010010, 32'h5555_6666);
    chk("t3_ok", 32'(slot1_ok), 32'd1);
    chk("t3_dout", 32'(slot1_dout), 32'h0000_6666);

    // Test 4: loop_rst wins over a coincident data_rdy
    slot0_cs = 1'b1;
    slot0_addr = 17'h00100;
    wait_req("t4", 22'h000080);
    do_ack("t4");
    step();
    loop_rst = 1'b1;
    data_rdy = 1'b1;
    data_read = 32'h1111_1111;
    step();
    loop_rst = 1'b0;
    data_rdy = 1'b0;
    chk("t4_abort_req", 32'(sdram_req), 32'd0);
    chk("t4_abort_ok", 32'(slot0_ok), 32'd0);
    step();
    chk("t4_reissue_req", 32'(sdram_req), 32'd1);
    chk("t4_reissue_addr", 32'(sdram_addr), 32'h000080);
    do_ack("t4b");
    do_rdy(32'hA1B2_C3D4);
    chk("t4_ok", 32'(slot0_ok), 32'd1);
    chk("t4_dout", 32'(slot0_dout), 32'h0000_00D4);

    // Test 5: downloading invalidates both caches and blocks requests
    chk("t5_pre_ok0", 32'(slot0_ok), 32'd1);
    chk("t5_pre_ok1", 32'(slot1_ok), 32'd1);
    downloading = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("t5_dl_ok0_%0d", i), 32'(slot0_ok), 32'd0);
      chk($sformatf("t5_dl_ok1_%0d", i), 32'(slot1_ok), 32'd0);
      chk($sformatf("t5_dl_req_%0d", i), 32'(sdram_req), 32'd0);
    end
    downloading = 1'b0;
    step();
    chk("t5_first_req", 32'(sdram_req), 32'd1);
    chk("t5_first_addr", 32'(sdram_addr), 32'h010010);
    do_ack("t5_s1");
    do_rdy(32'h7777_8888);
    serve("t5_s0", 22'h000080, 32'h0000_00EE);
    chk("t5_ok0", 32'(slot0_ok), 32'd1);
    chk("t5_dout0", 32'(slot0_dout), 32'h0000_00EE);
    chk("t5_ok1", 32'(slot1_ok), 32'd1);
    chk("t5_dout1", 32'(slot1_dout), 32'h0000_8888);

    // Test 6: asynchronous reset while a request is pending
    slot1_cs = 1'b0;
    slot0_addr = 17'h00200;
    step();
    chk("t6_req", 32'(sdram_req), 32'd1);
    chk("t6_addr", 32'(sdram_addr), 32'h000100);
    rst = 1'b1;
    #1;
    chk("t6_rst_req", 32'(sdram_req), 32'd0);
    chk("t6_rst_addr", 32'(sdram_addr), 32'd0);
    slot0_addr = 17'h00080;
    #1;
    chk("t6_rst_ok", 32'(slot0_ok), 32'd0);
    slot0_addr = 17'h00200;
    step();
    rst = 1'b0;
    step();
    chk("t6_after_req", 32'(sdram_req), 32'd1);
    chk("t6_after_addr", 32'(sdram_addr), 32'h000100);
    do_ack("t6");
    do_rdy(32'h0000_0042);
    chk("t6_ok", 32'(slot0_ok), 32'd1);
    chk("t6_dout", 32'(slot0_dout), 32'h0000_0042);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
